// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the forwarding / hazard controller:
// operand-select encodings, control FSM states and a select helper.
package fwd_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } ctrl_state_e;

    // Younger producer (EX/MEM) wins over older (MEM/WB).
    function automatic fwd_sel_e fwd_pick(input logic ex_hit,
                                          input logic mem_hit);
        if (ex_hit)
            return FWD_MEM;
        else if (mem_hit)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_hz_stage_reg.sv
// Shadow pipeline stage: {valid, rd, reg_write, mem_read}.
// Ports: clk, rst_n, nxt_* (next contents), valid/rd/reg_write/mem_read.
module hz_stage_reg #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          nxt_valid,
    input  logic [AW-1:0] nxt_rd,
    input  logic          nxt_reg_write,
    input  logic          nxt_mem_read,
    output logic          valid,
    output logic [AW-1:0] rd,
    output logic          reg_write,
    output logic          mem_read
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            rd        <= '0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
        end else begin
            valid     <= nxt_valid;
            rd        <= nxt_rd;
            reg_write <= nxt_reg_write;
            mem_read  <= nxt_mem_read;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use/branch hazard controller for a 5-stage core.
// Ports: ID-stage operand/dest info, branch_taken in; fwd selects,
// stall, flush_ex, flush_id and a saturating stall counter out.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              branch_taken,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              flush_ex,
    output logic              flush_id,
    output logic [CNT_W-1:0]  stall_count
);

    logic              ex_valid, ex_reg_write, ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_valid, mem_reg_write, mem_mem_read;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_valid, wb_reg_write, wb_mem_read;
    logic [REG_AW-1:0] wb_rd;

    logic              ex_src, mem_src, load_use;
    logic              ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    fwd_sel_e          sel_a, sel_b;
    ctrl_state_e       state, state_nxt;

    // A bubble enters EX whenever ID does not advance.
    hz_stage_reg #(.AW(REG_AW)) u_ex (
        .clk           (clk),
        .rst_n         (rst_n),
        .nxt_valid     (id_valid & ~flush_ex),
        .nxt_rd        (flush_ex ? '0 : id_rd),
        .nxt_reg_write (id_reg_write & ~flush_ex),
        .nxt_mem_read  (id_mem_read & ~flush_ex),
        .valid         (ex_valid),
        .rd            (ex_rd),
        .reg_write     (ex_reg_write),
        .mem_read      (ex_mem_read)
    );

    hz_stage_reg #(.AW(REG_AW)) u_mem (
        .clk           (clk),
        .rst_n         (rst_n),
        .nxt_valid     (ex_valid),
        .nxt_rd        (ex_rd),
        .nxt_reg_write (ex_reg_write),
        .nxt_mem_read  (ex_mem_read),
        .valid         (mem_valid),
        .rd            (mem_rd),
        .reg_write     (mem_reg_write),
        .mem_read      (mem_mem_read)
    );

    hz_stage_reg #(.AW(REG_AW)) u_wb (
        .clk           (clk),
        .rst_n         (rst_n),
        .nxt_valid     (mem_valid),
        .nxt_rd        (mem_rd),
        .nxt_reg_write (mem_reg_write),
        .nxt_mem_read  (mem_mem_read),
        .valid         (wb_valid),
        .rd            (wb_rd),
        .reg_write     (wb_reg_write),
        .mem_read      (wb_mem_read)
    );

    // WB is shadowed for pipeline completeness only.
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd, wb_reg_write,
                         wb_mem_read, mem_mem_read};

    assign ex_src  = ex_valid & ex_reg_write & (ex_rd != '0);
    assign mem_src = mem_valid & mem_reg_write & (mem_rd != '0);

    assign load_use = id_valid & ex_mem_read & ex_src &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

    assign stall    = load_use & ~branch_taken;
    assign flush_id = branch_taken & rst_n;
    assign flush_ex = stall | flush_id;

    // A load still in EX has no result yet, so it never feeds select 10.
    assign ex_hit_a  = id_use_rs1 & ex_src & ~ex_mem_read & (ex_rd == id_rs1);
    assign ex_hit_b  = id_use_rs2 & ex_src & ~ex_mem_read & (ex_rd == id_rs2);
    assign mem_hit_a = id_use_rs1 & mem_src & (mem_rd == id_rs1);
    assign mem_hit_b = id_use_rs2 & mem_src & (mem_rd == id_rs2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a <= FWD_RF;
            sel_b <= FWD_RF;
        end else if (flush_ex) begin
            sel_a <= FWD_RF;
            sel_b <= FWD_RF;
        end else begin
            sel_a <= fwd_pick(ex_hit_a, mem_hit_a);
            sel_b <= fwd_pick(ex_hit_b, mem_hit_b);
        end
    end

    assign fwd_a_sel = sel_a;
    assign fwd_b_sel = sel_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    // The stall bubble removes the load from EX, so STALL lasts one cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:   if (stall) state_nxt = ST_STALL;
            ST_STALL: state_nxt = ST_RUN;
        endcase
    end

endmodule
